game_mode_sm: RTL and testbench

Parametrised game-flow controller for the ball game. It generalises the single-shot survival sequencer into a full session manager with multiple lives, multiple levels, a per-level countdown and pause. It also supports a selectable timed or survival mode and restart from the terminal screens. It sits between the user-input/one-second-timer blocks and the ball/object drawing logic, gating draw requests and pulsing game start.

---
 rtl/game_mode_sm.sv | 159 +++++++++++++++
 tb/tb_game_mode_sm.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_mode_sm.sv
// Session manager for the ball game: lives, levels, per-level countdown, pause
// and restart, gating ball drawing and pulsing startGame at each level start.
module game_mode_sm #(
  parameter int LIVES       = 3,
  parameter int LEVELS      = 4,
  parameter int ROUND_SEC   = 60,
  parameter int RESPAWN_SEC = 2,
  localparam int LIVES_W    = $clog2(LIVES + 1),
  localparam int LEVEL_W    = (LEVELS > 1) ? $clog2(LEVELS) : 1,
  localparam int TIME_W     = $clog2(ROUND_SEC + 1),
  localparam int RESP_W     = $clog2(RESPAWN_SEC + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startN,
  input  logic               pauseReq,
  input  logic               hit,
  input  logic               levelClear,
  input  logic               secTick,
  input  logic               timedMode,
  output logic               startGame,
  output logic               drawEnable,
  output logic               paused,
  output logic               gameOver,
  output logic               win,
  output logic [LIVES_W-1:0] livesLeft,
  output logic [LEVEL_W-1:0] level,
  output logic [TIME_W-1:0]  timeLeft
);

  typedef enum logic [2:0] {
    IDLE, PLAY, PAUSE, RESPAWN, LEVEL_UP, GAME_OVER, WIN
  } state_t;

  state_t             state, stateNext;
  logic [LIVES_W-1:0] livesNext;
  logic [LEVEL_W-1:0] levelNext;
  logic [TIME_W-1:0]  timeNext;
  logic [RESP_W-1:0]  respCnt, respNext;
  logic               armed, armedNext;
  logic               startGameQ, startGameNext;
  logic               levelDone;
  logic               expiry;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      livesLeft  <= LIVES_W'(LIVES);
      level      <= '0;
      timeLeft   <= TIME_W'(ROUND_SEC);
      respCnt    <= '0;
      armed      <= 1'b0;
      startGameQ <= 1'b0;
    end else begin
      state      <= stateNext;
      livesLeft  <= livesNext;
      level      <= levelNext;
      timeLeft   <= timeNext;
      respCnt    <= respNext;
      armed      <= armedNext;
      startGameQ <= startGameNext;
    end
  end

  assign expiry = secTick && (timeLeft == TIME_W'(1));

  always_comb begin
    stateNext     = state;
    livesNext     = livesLeft;
    levelNext     = level;
    timeNext      = timeLeft;
    respNext      = respCnt;
    armedNext     = armed;
    startGameNext = 1'b0;
    levelDone     = 1'b0;
    case (state)
      IDLE: begin
        if (!startN) begin
          stateNext     = PLAY;
          livesNext     = LIVES_W'(LIVES);
          levelNext     = '0;
          timeNext      = TIME_W'(ROUND_SEC);
          startGameNext = 1'b1;
        end
      end
      PLAY: begin
        // A hit swallows every other event of the cycle, including the tick.
        if (hit) begin
          livesNext = livesLeft - LIVES_W'(1);
          if (livesLeft == LIVES_W'(1)) begin
            stateNext = GAME_OVER;
            armedNext = 1'b0;
          end else begin
            stateNext = RESPAWN;
            respNext  = '0;
          end
        end else begin
          if (secTick) timeNext = timeLeft - TIME_W'(1);
          if (expiry) begin
            if (timedMode) begin
              stateNext = GAME_OVER;
              armedNext = 1'b0;
            end else begin
              levelDone = 1'b1;
            end
          end else if (levelClear) begin
            levelDone = 1'b1;
          end else if (pauseReq) begin
            stateNext = PAUSE;
          end
          if (levelDone) begin
            if (level == LEVEL_W'(LEVELS - 1)) begin
              stateNext = WIN;
              armedNext = 1'b0;
            end else begin
              stateNext = LEVEL_UP;
            end
          end
        end
      end
      PAUSE: begin
        if (pauseReq) stateNext = PLAY;
      end
      RESPAWN: begin
        if (secTick) begin
          respNext = respCnt + RESP_W'(1);
          if (respCnt == RESP_W'(RESPAWN_SEC - 1)) stateNext = PLAY;
        end
      end
      LEVEL_UP: begin
        stateNext     = PLAY;
        levelNext     = level + LEVEL_W'(1);
        timeNext      = TIME_W'(ROUND_SEC);
        startGameNext = 1'b1;
      end
      GAME_OVER, WIN: begin
        // Restart needs a release seen first, so a held button never re-arms.
        if (startN) begin
          armedNext = 1'b1;
        end else if (armed) begin
          stateNext = IDLE;
          livesNext = LIVES_W'(LIVES);
          levelNext = '0;
          timeNext  = TIME_W'(ROUND_SEC);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    startGame  = startGameQ;
    drawEnable = (state == PLAY);
    paused     = (state == PAUSE);
    gameOver   = (state == GAME_OVER);
    win        = (state == WIN);
  end

endmodule

// File: tb/tb_game_mode_sm.sv
// Bench for game_mode_sm: directed scenarios with fixed expectations, then
// random traffic compared every cycle against a rule-level reference model.
module tb_game_mode_sm;
  localparam int L  = 3;
  localparam int LV = 4;
  localparam int RS = 3;
  localparam int RP = 2;

  logic clk = 1'b0;
  logic reset = 1'b1, startN = 1'b1, pauseReq = 1'b0, hit = 1'b0;
  logic levelClear = 1'b0, secTick = 1'b0, timedMode = 1'b0;
  logic startGame, drawEnable, paused, gameOver, win;
  logic [1:0] livesLeft, level, timeLeft;

  int total = 0;
  int bad   = 0;

  // Reference model: screen phase plus counters kept as plain integers.
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_BLANK = 3,
                 M_NEXT = 4, M_LOST = 5, M_WON = 6;
  int mPhase = M_IDLE, mLives = L, mLevel = 0, mTime = RS, mSecs = 0;
  bit mArmed = 0, mStart = 0;

  game_mode_sm #(.LIVES(L), .LEVELS(LV), .ROUND_SEC(RS), .RESPAWN_SEC(RP)) dut (
    .clk(clk), .reset(reset), .startN(startN), .pauseReq(pauseReq), .hit(hit),
    .levelClear(levelClear), .secTick(secTick), .timedMode(timedMode),
    .startGame(startGame), .drawEnable(drawEnable), .paused(paused),
    .gameOver(gameOver), .win(win), .livesLeft(livesLeft), .level(level),
    .timeLeft(timeLeft)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic newSession();
    mLives = L; mLevel = 0; mTime = RS;
  endtask

  task automatic modelStep();
    bit cleared;
    mStart = 0;
    if (reset) begin
      mPhase = M_IDLE; newSession(); mSecs = 0; mArmed = 0;
      return;
    end
    case (mPhase)
      M_IDLE: if (!startN) begin mPhase = M_PLAY; newSession(); mStart = 1; end
      M_PLAY: begin
        if (hit) begin
          mLives = mLives - 1;
          if (mLives == 0) begin mPhase = M_LOST; mArmed = 0; end
          else begin mPhase = M_BLANK; mSecs = 0; end
        end else begin
          cleared = 0;
          if (secTick) mTime = mTime - 1;
          if (secTick && mTime == 0) begin
            if (timedMode) begin mPhase = M_LOST; mArmed = 0; end
            else cleared = 1;
          end else if (levelClear) cleared = 1;
          else if (pauseReq) mPhase = M_PAUSE;
          if (cleared) begin
            if (mLevel == LV - 1) begin mPhase = M_WON; mArmed = 0; end
            else mPhase = M_NEXT;
          end
        end
      end
      M_PAUSE: if (pauseReq) mPhase = M_PLAY;
      M_BLANK: if (secTick) begin
        mSecs++;
        if (mSecs == RP) mPhase = M_PLAY;
      end
      M_NEXT: begin mPhase = M_PLAY; mLevel++; mTime = RS; mStart = 1; end
      default: begin
        if (startN) mArmed = 1;
        else if (mArmed) begin mPhase = M_IDLE; newSession(); end
      end
    endcase
  endtask

  // One clock: inputs already set; model advances on the same edge, outputs
  // are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    modelStep();
    chk("m_startGame", startGame, mStart);
    chk("m_drawEnable", drawEnable, mPhase == M_PLAY);
    chk("m_paused", paused, mPhase == M_PAUSE);
    chk("m_gameOver", gameOver, mPhase == M_LOST);
    chk("m_win", win, mPhase == M_WON);
    chk("m_livesLeft", livesLeft, mLives);
    chk("m_level", level, mLevel);
    chk("m_timeLeft", timeLeft, mTime);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse(input int which);
    case (which)
      0: hit = 1'b1;
      1: levelClear = 1'b1;
      2: secTick = 1'b1;
      default: pauseReq = 1'b1;
    endcase
    tick();
    hit = 1'b0; levelClear = 1'b0; secTick = 1'b0; pauseReq = 1'b0;
  endtask

  task automatic restart();
    startN = 1'b1; tick();
    startN = 1'b0; tick();
    chk("restart_idle_draw", drawEnable, 0);
    tick();
    chk("restart_startGame", startGame, 1);
    startN = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    ticks(2);
    chk("rst_lives", livesLeft, 3);
    chk("rst_level", level, 0);
    chk("rst_time", timeLeft, RS);
    chk("rst_draw", drawEnable, 0);
    reset = 1'b0;
    tick();
    startN = 1'b0; tick();
    chk("start_sg", startGame, 1);
    chk("start_draw", drawEnable, 1);
    chk("start_lives", livesLeft, 3);
    startN = 1'b1; tick();
    chk("start_sg_low", startGame, 0);

    // Hits and respawn
    pulse(0);
    chk("hit1_lives", livesLeft, 2);
    chk("hit1_draw", drawEnable, 0);
    pulse(2);
    chk("resp_still_blank", drawEnable, 0);
    pulse(2);
    chk("resp_back_draw", drawEnable, 1);
    chk("resp_no_sg", startGame, 0);
    chk("resp_time", timeLeft, RS);
    pulse(0); pulse(2); pulse(2);
    pulse(0);
    chk("hit3_over", gameOver, 1);
    chk("hit3_lives", livesLeft, 0);
    restart();

    // Timed expiry ends the game
    timedMode = 1'b1;
    pulse(2); pulse(2); pulse(2);
    chk("timed_time", timeLeft, 0);
    chk("timed_over", gameOver, 1);
    restart();

    // Survival expiry clears the level
    timedMode = 1'b0;
    pulse(2); pulse(2); pulse(2);
    chk("surv_levelup_draw", drawEnable, 0);
    tick();
    chk("surv_level", level, 1);
    chk("surv_time", timeLeft, RS);
    chk("surv_sg", startGame, 1);

    // hit + levelClear + expiring tick together: hit wins
    pulse(2); pulse(2);
    hit = 1'b1; levelClear = 1'b1; secTick = 1'b1; tick();
    hit = 1'b0; levelClear = 1'b0; secTick = 1'b0;
    chk("prio_lives", livesLeft, 2);
    chk("prio_level", level, 1);
    chk("prio_time", timeLeft, 1);
    pulse(2); pulse(2);

    // Pause freezes everything
    pulse(3);
    chk("pause_on", paused, 1);
    for (int k = 0; k < 5; k++) pulse(2);
    pulse(0);
    chk("pause_time", timeLeft, 1);
    chk("pause_lives", livesLeft, 2);
    chk("pause_still", paused, 1);
    pulse(3);
    chk("pause_off", paused, 0);
    chk("pause_draw", drawEnable, 1);

    // Win, held button, rearm
    pulse(1); tick(); pulse(1); tick();
    chk("lvl3", level, 3);
    startN = 1'b0;
    pulse(1);
    chk("win_on", win, 1);
    ticks(4);
    chk("win_held", win, 1);
    startN = 1'b1; tick();
    startN = 1'b0; tick();
    chk("rearm_idle_win", win, 0);
    chk("rearm_idle_lives", livesLeft, 3);
    tick();
    chk("rearm_play_draw", drawEnable, 1);
    chk("rearm_level", level, 0);

    // Reset mid-play
    pulse(2);
    reset = 1'b1; tick();
    chk("mid_rst_draw", drawEnable, 0);
    chk("mid_rst_time", timeLeft, RS);
    chk("mid_rst_sg", startGame, 0);
    reset = 1'b0; startN = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 6000; i++) begin
      reset      = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 5) == 0) startN = ~startN;
      if ($urandom_range(0, 49) == 0) timedMode = ~timedMode;
      pauseReq   = ($urandom_range(0, 19) == 0);
      hit        = ($urandom_range(0, 29) == 0);
      levelClear = ($urandom_range(0, 24) == 0);
      secTick    = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
